// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM path: access-sequencer states,
// the data-memory base address, and the byte-address to SRAM-word mapping.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int ARM_MEM_BASE = 1024;

  // 32-bit word index inside the 256K x 16 SRAM; the byte offset is dropped.
  function automatic logic [16:0] sram_word_of(input logic [31:0] addr,
                                               input logic [31:0] base);
    return 17'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/arm_sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases with
// programmable wait cycles; ready low freezes the pipeline meanwhile.
module arm_sram_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BASE    = ARM_MEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e       r_state;
  mem_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_op_write;
  logic [16:0]      r_word;
  logic [31:0]      r_wdata;
  logic [31:0]      r_read_data;
  logic [17:0]      r_sram_addr;

  logic             w_req;
  logic             w_phase_end;
  logic             w_drive;
  logic [15:0]      w_dq_out;
  logic [16:0]      w_word;

  assign w_req       = wr_en | rd_en;
  assign w_word      = sram_word_of(address, 32'(MEM_BASE));
  assign w_phase_end = (r_cnt == CNT_LAST);

  // The bus is only ours during the two phases of a store.
  assign w_drive   = r_op_write && ((r_state == LO) || (r_state == HI));
  assign w_dq_out  = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
  assign SRAM_WE_N = ~w_drive;
  assign SRAM_ADDR = r_sram_addr;
  assign read_data = r_read_data;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ready        = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_state_next = LO;
          w_cnt_next   = '0;
        end
      end
      LO: begin
        if (w_phase_end) begin
          w_state_next = HI;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      HI: begin
        if (w_phase_end) begin
          w_state_next = DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      DONE: begin
        ready        = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, and all state uses <= so
  // every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_write  <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op_write  <= wr_en;
            r_word      <= w_word;
            r_wdata     <= write_data;
            r_sram_addr <= {w_word, 1'b0};
          end
        end
        LO: begin
          if (w_phase_end) begin
            if (!r_op_write) r_read_data[15:0] <= SRAM_DQ;
            r_sram_addr <= {r_word, 1'b1};
          end
        end
        HI: begin
          if (w_phase_end && !r_op_write) r_read_data[31:16] <= SRAM_DQ;
        end
        default: ;
      endcase
    end
  end

endmodule
